icache_ctrl: RTL and testbench

Sequencing controller for the instruction cache: accepts fetch requests from the CPU front end, drives the tag store's query and write ports and the line data RAM, and refills missing lines from the memory bus with an 8-beat read burst. It also runs the whole-cache invalidation sweep after reset and on software request. It sits between the fetch stage and the bus interface, with the tag store and data RAM as its datapath.

---
 rtl/icache_ctrl_pkg.sv | 26 ++
 rtl/icache_refill_cnt.sv | 40 ++++
 rtl/icache_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction-cache sequencer.
// Holds geometry defaults, address field positions and the controller state encoding.
// No logic; imported by icache_ctrl and icache_refill_cnt.
package icache_ctrl_pkg;

  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned INDEX_W_DEF    = 7;
  localparam int unsigned TAG_W_DEF      = 20;

  // Byte-within-word bits sit below the word offset in every fetch address.
  localparam int unsigned WORD_LSB    = 2;
  localparam int unsigned OFF_W_DEF   = $clog2(LINE_WORDS_DEF);
  localparam int unsigned IDX_LSB_DEF = WORD_LSB + OFF_W_DEF;
  localparam int unsigned TAG_LSB_DEF = IDX_LSB_DEF + INDEX_W_DEF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_TAGWR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/icache_refill_cnt.sv
// Refill beat counter with critical-word capture for one line burst.
// Latency: counter and captured word update on the edge that accepts a beat.
// Backpressure: none; every beat_vld cycle is consumed. clr holds the counter at 0.
// Ports: beat_vld/beat_dat = accepted bus beat, req_off = word the CPU asked for,
//        beat_cnt = index of the beat currently on the bus, last_beat = final beat
//        accepted this cycle, crit_dat = captured requested word.
module icache_refill_cnt
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned OFF_W = OFF_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             beat_vld,
  input  logic [OFF_W-1:0] req_off,
  input  logic [31:0]      beat_dat,
  output logic [OFF_W-1:0] beat_cnt,
  output logic             last_beat,
  output logic [31:0]      crit_dat
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= '0;
      crit_dat <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (beat_vld) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (beat_cnt == req_off) begin
        crit_dat <= beat_dat;
      end
    end
  end

  // The counter, not the bus last flag, decides where the line ends.
  assign last_beat = beat_vld && (beat_cnt == {OFF_W{1'b1}});

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache sequencer: lookup, line refill over an 8-beat burst, full invalidate sweep.
// Latency: hit response 2 cycles after request handshake; miss response 2 cycles after last beat.
// Backpressure: req_ready only in IDLE with no invalidate pending; mem_rd_req held until mem_rd_ready.
// Ports: req_* fetch handshake, resp_* one-cycle instruction pulse, tag_* tag store query/write,
//        data_* line RAM read/write, mem_rd_* burst read bus, inv_req/inv_done invalidate.
// Option: ICACHE_STATS_EN adds hit_cnt/miss_cnt lookup counters.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter  int unsigned INDEX_W    = INDEX_W_DEF,
  parameter  int unsigned TAG_W      = TAG_W_DEF,
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic [INDEX_W-1:0]       tag_qindex,
  output logic [TAG_W-1:0]         tag_qtag,
  input  logic                     tag_hit,
  output logic                     tag_wen,
  output logic [INDEX_W-1:0]       tag_windex,
  output logic [TAG_W-1:0]         tag_wtag,
  output logic                     tag_valid,
  output logic [INDEX_W+OFF_W-1:0] data_raddr,
  input  logic [31:0]              data_rdata,
  output logic                     data_wen,
  output logic [INDEX_W+OFF_W-1:0] data_waddr,
  output logic [31:0]              data_wdata,
  output logic                     mem_rd_req,
  input  logic                     mem_rd_ready,
  output logic [31:0]              mem_rd_addr,
  input  logic                     mem_rd_valid,
  input  logic [31:0]              mem_rd_data,
  input  logic                     mem_rd_last,
  input  logic                     inv_req,
  output logic                     inv_done
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
`endif
);

  localparam int unsigned IDX_LSB = WORD_LSB + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + INDEX_W;

  state_t             state, state_nxt;
  logic [INDEX_W-1:0] sweep_cnt;
  logic               sweep_last;
  logic               inv_pend;
  logic               inv_sweep;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [OFF_W-1:0]   off_q;
  logic [OFF_W-1:0]   beat_cnt;
  logic               last_beat;
  logic [31:0]        crit_dat;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^req_addr[WORD_LSB-1:0];
  assign sweep_last       = (sweep_cnt == {INDEX_W{1'b1}});

  icache_refill_cnt #(.OFF_W(OFF_W)) u_refill_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (state != ST_REFILL),
    .beat_vld  ((state == ST_REFILL) && mem_rd_valid),
    .req_off   (off_q),
    .beat_dat  (mem_rd_data),
    .beat_cnt  (beat_cnt),
    .last_beat (last_beat),
    .crit_dat  (crit_dat)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_INIT;
      sweep_cnt  <= '0;
      inv_pend   <= 1'b0;
      inv_sweep  <= 1'b0;
      tag_q      <= '0;
      index_q    <= '0;
      off_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      inv_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      inv_done   <= 1'b0;

      // Counter wraps back to 0 on the last sweep write, ready for the next sweep.
      if (state == ST_INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end

      // An invalidate seen in IDLE starts a sweep now; anywhere else it waits.
      if (state == ST_IDLE && (inv_req || inv_pend)) begin
        inv_sweep <= 1'b1;
        inv_pend  <= 1'b0;
      end else if (inv_req) begin
        inv_pend <= 1'b1;
      end

      // Only software-requested sweeps report completion.
      if (state == ST_INIT && sweep_last) begin
        inv_done  <= inv_sweep;
        inv_sweep <= 1'b0;
      end

      if (req_valid && req_ready) begin
        tag_q   <= req_addr[TAG_LSB +: TAG_W];
        index_q <= req_addr[IDX_LSB +: INDEX_W];
        off_q   <= req_addr[WORD_LSB +: OFF_W];
      end

      if (state == ST_LOOKUP && tag_hit) begin
        resp_valid <= 1'b1;
        resp_rdata <= data_rdata;
      end

      // Loading here makes the response visible during the RESP cycle.
      if (state == ST_TAGWR) begin
        resp_valid <= 1'b1;
        resp_rdata <= crit_dat;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_rd_req = 1'b0;
    tag_wen    = 1'b0;
    tag_valid  = 1'b0;
    data_wen   = 1'b0;
    case (state)
      ST_INIT: begin
        // Reset parks the FSM in INIT; keep the tag store untouched until release.
        tag_wen = resetn;
        if (sweep_last) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (inv_req || inv_pend) begin
          state_nxt = ST_INIT;
        end else begin
          req_ready = 1'b1;
          if (req_valid) state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        state_nxt = tag_hit ? ST_IDLE : ST_MISS;
      end
      ST_MISS: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ready) state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        data_wen = mem_rd_valid;
        if (last_beat) state_nxt = ST_TAGWR;
      end
      ST_TAGWR: begin
        tag_wen   = 1'b1;
        tag_valid = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign tag_qindex  = index_q;
  assign tag_qtag    = tag_q;
  assign tag_windex  = (state == ST_INIT) ? sweep_cnt : index_q;
  assign tag_wtag    = (state == ST_INIT) ? '0 : tag_q;
  assign data_raddr  = {index_q, off_q};
  assign data_waddr  = {index_q, beat_cnt};
  assign data_wdata  = mem_rd_data;
  assign mem_rd_addr = {tag_q, index_q, {(OFF_W + WORD_LSB){1'b0}}};

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_LOOKUP) begin
      if (tag_hit) hit_cnt  <= hit_cnt + 32'd1;
      else         miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_last_matches_cnt: assert property (@(posedge clk) disable iff (!resetn)
    (state == ST_REFILL && mem_rd_valid) |-> (mem_rd_last == last_beat));
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural tag store, line RAM and burst memory around the DUT,
// with a line-level cache model deciding hit/miss and the expected instruction word.
module tb_icache_ctrl;

  localparam int IW = 7;
  localparam int TW = 20;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid, req_ready;
  logic [31:0]   req_addr;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [IW-1:0] tag_qindex, tag_windex;
  logic [TW-1:0] tag_qtag, tag_wtag;
  logic          tag_hit, tag_wen, tag_valid;
  logic [IW+2:0] data_raddr, data_waddr;
  logic [31:0]   data_rdata, data_wdata;
  logic          data_wen;
  logic          mem_rd_req, mem_rd_ready, mem_rd_valid, mem_rd_last;
  logic [31:0]   mem_rd_addr, mem_rd_data;
  logic          inv_req, inv_done;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .tag_qindex(tag_qindex), .tag_qtag(tag_qtag), .tag_hit(tag_hit),
    .tag_wen(tag_wen), .tag_windex(tag_windex), .tag_wtag(tag_wtag), .tag_valid(tag_valid),
    .data_raddr(data_raddr), .data_rdata(data_rdata),
    .data_wen(data_wen), .data_waddr(data_waddr), .data_wdata(data_wdata),
    .mem_rd_req(mem_rd_req), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
    .inv_req(inv_req), .inv_done(inv_done)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // Datapath models driven by the DUT
  logic          tvalid_m [128];
  logic [TW-1:0] ttag_m   [128];
  logic [31:0]   dram     [1024];
  assign tag_hit    = tvalid_m[tag_qindex] && (ttag_m[tag_qindex] == tag_qtag);
  assign data_rdata = dram[data_raddr];

  // Posedge monitor: applies writes and timestamps events
  int            cyc = 0;
  int            tag_wr_cnt, tag_wr_vld_cnt, data_wr_cnt, inv_done_cnt, resp_cnt;
  int            hs_cyc, resp_cyc, last_cyc, first_req_cyc;
  bit            req_seen;
  logic [IW-1:0] last_tw_idx;
  logic [TW-1:0] last_tw_tag;
  logic          last_tw_vld;
  logic [31:0]   resp_dat;

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      // Stale valid tags matching early fetches: only a working sweep hides them.
      for (int i = 0; i < 128; i++) begin
        tvalid_m[i] <= 1'b1;
        ttag_m[i]   <= 20'h00001;
      end
      for (int i = 0; i < 1024; i++) dram[i] <= 32'hDEAD_0000 | i;
      tag_wr_cnt = 0; tag_wr_vld_cnt = 0; data_wr_cnt = 0; inv_done_cnt = 0; resp_cnt = 0;
      hs_cyc = 0; resp_cyc = 0; last_cyc = 0; first_req_cyc = 0; req_seen = 1'b0;
    end else begin
      if (tag_wen) begin
        tvalid_m[tag_windex] <= tag_valid;
        ttag_m[tag_windex]   <= tag_wtag;
        tag_wr_cnt++;
        if (tag_valid) tag_wr_vld_cnt++;
        last_tw_idx = tag_windex; last_tw_tag = tag_wtag; last_tw_vld = tag_valid;
      end
      if (data_wen) begin
        dram[data_waddr] <= data_wdata;
        data_wr_cnt++;
      end
      if (inv_done) inv_done_cnt++;
      if (req_valid && req_ready) begin hs_cyc = cyc; req_seen = 1'b0; end
      if (mem_rd_req && !req_seen) begin req_seen = 1'b1; first_req_cyc = cyc; end
      if (mem_rd_valid && mem_rd_last) last_cyc = cyc;
      if (resp_valid) begin resp_cnt++; resp_cyc = cyc; resp_dat = resp_rdata; end
    end
  end

  // Burst memory: optional ready delay, random gaps between beats
  int          ready_delay = 0;
  int          burst_cnt, bus_beat, hold;
  bit          bus_busy, waiting;
  logic [31:0] first_addr, burst_addr;

  always @(negedge clk) begin
    if (!resetn) begin
      bus_busy = 0; waiting = 0; burst_cnt = 0; bus_beat = 0; hold = 0;
      mem_rd_ready = 0; mem_rd_valid = 0; mem_rd_last = 0; mem_rd_data = '0;
    end else begin
      if (mem_rd_valid) begin
        bus_beat++;
        if (bus_beat == LW) bus_busy = 0;
      end
      if (mem_rd_ready) begin
        bus_busy = 1; bus_beat = 0; burst_cnt++; burst_addr = first_addr; waiting = 0;
      end
      mem_rd_ready = 0; mem_rd_valid = 0; mem_rd_last = 0;
      if (bus_busy) begin
        if ($urandom_range(0, 3) != 0) begin
          mem_rd_valid = 1;
          mem_rd_data  = memfn(burst_addr + 32'(bus_beat) * 4);
          mem_rd_last  = (bus_beat == LW - 1);
        end
      end else begin
        if (waiting) begin
          chk("rd_req_held", {31'd0, mem_rd_req}, 32'd1);
          chk("rd_addr_stable", mem_rd_addr, first_addr);
        end else if (mem_rd_req) begin
          waiting = 1; first_addr = mem_rd_addr; hold = 0;
        end
        if (waiting) begin
          if (hold >= ready_delay) mem_rd_ready = 1;
          else hold++;
        end
      end
    end
  end

  // Line-level reference: which lines are resident and with what tag
  bit            ref_valid [128];
  logic [TW-1:0] ref_tag   [128];

  task automatic ref_invalidate();
    for (int i = 0; i < 128; i++) ref_valid[i] = 0;
  endtask

  task automatic wait_inv_done(input int i0, input int tw0);
    int n = 0;
    while (inv_done_cnt == i0 && n < 400) begin @(negedge clk); n++; end
    chk("inv_done_tmo", 32'(n < 400), 32'd1);
    chk("inv_done_pulses", 32'(inv_done_cnt - i0), 32'd1);
    chk("inv_sweep_writes", 32'(tag_wr_cnt - tw0), 32'd128);
    ref_invalidate();
  endtask

  task automatic fetch(input logic [31:0] addr, input bit inv_mid);
    logic [IW-1:0] idx;
    logic [TW-1:0] tg;
    bit            exp_hit, sent;
    int            b0, d0, r0, n;
    idx = addr[11:5];
    tg  = addr[31:12];
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    b0 = burst_cnt; d0 = data_wr_cnt; r0 = resp_cnt; sent = 0;
    req_addr = addr; req_valid = 1;
    n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    chk("req_ready_tmo", 32'(n < 1000), 32'd1);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (resp_cnt == r0 && n < 1000) begin
      if (inv_mid && !sent && data_wr_cnt > d0) begin inv_req = 1; sent = 1; end
      else inv_req = 0;
      @(negedge clk); n++;
    end
    inv_req = 0;
    chk("resp_tmo", 32'(n < 1000), 32'd1);
    chk("resp_pulse_width", {31'd0, resp_valid}, 32'd0);
    chk("resp_data", resp_dat, memfn(addr));
    chk("burst_count", 32'(burst_cnt - b0), exp_hit ? 32'd0 : 32'd1);
    if (exp_hit) begin
      chk("hit_latency", 32'(resp_cyc - hs_cyc), 32'd2);
    end else begin
      chk("miss_req_latency", 32'(first_req_cyc - hs_cyc), 32'd2);
      chk("miss_resp_after_last", 32'(resp_cyc - last_cyc), 32'd2);
      chk("burst_addr", burst_addr, {addr[31:5], 5'd0});
      chk("data_writes", 32'(data_wr_cnt - d0), 32'd8);
      chk("tagwr_index", 32'(last_tw_idx), 32'(idx));
      chk("tagwr_tag", 32'(last_tw_tag), 32'(tg));
      chk("tagwr_valid", {31'd0, last_tw_vld}, 32'd1);
      ref_valid[idx] = 1;
      ref_tag[idx]   = tg;
    end
  endtask

  logic [TW-1:0] pool [4];

  initial begin
    int i0, tw0, v0;
    logic [IW-1:0] ridx;
    logic [2:0]    roff;
    req_valid = 0; req_addr = '0; inv_req = 0;
    pool[0] = 20'h00001; pool[1] = 20'h00002; pool[2] = 20'h00009; pool[3] = 20'h00033;
    ref_invalidate();

    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_tag_wen",    {31'd0, tag_wen},    32'd0);
    chk("rst_data_wen",   {31'd0, data_wen},   32'd0);
    chk("rst_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst_inv_done",   {31'd0, inv_done},   32'd0);

    // Post-reset sweep: 128 invalidating writes, then ready
    resetn = 1;
    repeat (127) @(negedge clk);
    chk("ready_before_sweep_end", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_at_cycle_128", {31'd0, req_ready}, 32'd1);
    chk("init_tag_writes", 32'(tag_wr_cnt), 32'd128);
    chk("init_valid_writes", 32'(tag_wr_vld_cnt), 32'd0);
    chk("init_no_inv_done", 32'(inv_done_cnt), 32'd0);

    fetch(32'h0000_1004, 0);   // cold miss, critical word is beat 1
    fetch(32'h0000_1008, 0);   // same line hit
    ready_delay = 5;
    fetch(32'h0000_9004, 0);   // same index, new tag, slow bus grant
    ready_delay = 0;
    chk("conflict_tag", 32'(ttag_m[0]), 32'h00009);
    fetch(32'h0000_901C, 0);   // last word of the new line, hit

    // Invalidate during refill: refill completes, then a full sweep
    i0 = inv_done_cnt;
    fetch(32'h0000_2020, 1);
    tw0 = tag_wr_cnt;
    wait_inv_done(i0, tw0);
    fetch(32'h0000_1008, 0);   // line gone after invalidate

    // Invalidate and request in the same IDLE cycle: invalidate wins
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    i0 = inv_done_cnt; tw0 = tag_wr_cnt; v0 = tag_wr_vld_cnt;
    inv_req = 1; req_valid = 1; req_addr = 32'h0000_1008;
    #1;
    chk("inv_beats_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    inv_req = 0; req_valid = 0;
    wait_inv_done(i0, tw0);
    chk("sweep_no_valid_writes", 32'(tag_wr_vld_cnt - v0), 32'd0);
    fetch(32'h0000_1008, 0);

    // Random fetches over a few conflicting lines
    for (int k = 0; k < 40; k++) begin
      ridx = 7'($urandom_range(0, 3));
      roff = 3'($urandom_range(0, 7));
      ready_delay = $urandom_range(0, 3);
      fetch({pool[$urandom_range(0, 3)], ridx, roff, 2'b00}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
